// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: serialises CPU and DMA accesses onto one memory port; CPU has fixed priority with DMA starvation relief.
// Define ARB_TIMEOUT_EN to end a BUSY access with bus_err when mem_ready is missing for TIMEOUT cycles.
module mem_bus_arbiter #(
    parameter int AW = 16,
    parameter int DW = 16,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT = 15
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cpu_read,
    input  logic          cpu_write,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_mfc,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_read,
    input  logic          dma_write,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_mfc,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          owner,
    output logic          bus_err
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;
    state_t state;
    logic [SW-1:0] starve_cnt;
    logic cpu_pend, dma_pend, dma_win, grant_read, own_pend, timeout, done;
    logic [DW-1:0] fill;
`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt;
`endif
    always_comb begin
        cpu_pend = cpu_read | cpu_write;
        dma_pend = dma_read | dma_write;
        dma_win = dma_pend && (starve_cnt == SW'(STARVE_LIMIT) || !cpu_pend);
        grant_read = dma_win ? dma_read : cpu_read;
        own_pend = owner ? dma_pend : cpu_pend;
`ifdef ARB_TIMEOUT_EN
        timeout = !mem_ready && tcnt == TW'(TIMEOUT - 1);
`else
        timeout = 1'b0;
`endif
        done = mem_ready || timeout;
        fill = timeout ? '0 : mem_rdata;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            starve_cnt <= '0;
            owner <= 1'b0;
            mem_read <= 1'b0;
            mem_write <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            cpu_mfc <= 1'b0;
            dma_mfc <= 1'b0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
            bus_err <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            tcnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_pend || dma_pend) begin
                        owner <= dma_win;
                        mem_addr <= dma_win ? dma_addr : cpu_addr;
                        mem_wdata <= dma_win ? dma_wdata : cpu_wdata;
                        mem_read <= grant_read;
                        mem_write <= !grant_read;
                        state <= BUSY;
                    end
                    // a CPU win over a waiting DMA can only happen below the limit, so this never overflows
                    starve_cnt <= (cpu_pend && dma_pend && !dma_win) ? starve_cnt + SW'(1) : '0;
`ifdef ARB_TIMEOUT_EN
                    tcnt <= '0;
`endif
                end
                BUSY: begin
                    if (done) begin
                        mem_read <= 1'b0;
                        mem_write <= 1'b0;
                        cpu_mfc <= !owner;
                        dma_mfc <= owner;
                        bus_err <= timeout;
                        if (mem_read && !owner) cpu_rdata <= fill;
                        if (mem_read && owner) dma_rdata <= fill;
                        state <= HOLD;
                    end
`ifdef ARB_TIMEOUT_EN
                    tcnt <= tcnt + TW'(1);
`endif
                end
                HOLD: begin
                    if (!own_pend) begin
                        cpu_mfc <= 1'b0;
                        dma_mfc <= 1'b0;
                        bus_err <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed and randomized checks of mem_bus_arbiter against a transaction-level requester/memory model.
// Exercises the timeout path when ARB_TIMEOUT_EN is defined.
module tb_mem_bus_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int LIMIT = 4;
    localparam int TMO = 15;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic cpu_read, cpu_write, dma_read, dma_write, mem_ready;
    logic [AW-1:0] cpu_addr, dma_addr;
    logic [DW-1:0] cpu_wdata, dma_wdata, mem_rdata;
    logic cpu_mfc, dma_mfc, mem_read, mem_write, owner, bus_err;
    logic [DW-1:0] cpu_rdata, dma_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    mem_bus_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_mfc(cpu_mfc), .cpu_rdata(cpu_rdata),
        .dma_read(dma_read), .dma_write(dma_write), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_mfc(dma_mfc), .dma_rdata(dma_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .owner(owner), .bus_err(bus_err)
    );
    always #5 clock = ~clock;
    int n_cmp = 0;
    int n_err = 0;
    int starve = 0;
    logic pend [2];
    logic rq_rd [2];
    logic rq_wr [2];
    logic [AW-1:0] rq_addr [2];
    logic [DW-1:0] rq_wdata [2];
    logic [DW-1:0] exp_rdata [2];
    logic [DW-1:0] mem_arr [logic [AW-1:0]];
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        return mem_arr.exists(a) ? mem_arr[a] : a ^ 16'h5a3c;
    endfunction
    function automatic logic mfc_of(input int i);
        return i != 0 ? dma_mfc : cpu_mfc;
    endfunction
    function automatic logic [DW-1:0] rdata_of(input int i);
        return i != 0 ? dma_rdata : cpu_rdata;
    endfunction
    task automatic drive();
        cpu_read = pend[0] & rq_rd[0];
        cpu_write = pend[0] & rq_wr[0];
        cpu_addr = rq_addr[0];
        cpu_wdata = rq_wdata[0];
        dma_read = pend[1] & rq_rd[1];
        dma_write = pend[1] & rq_wr[1];
        dma_addr = rq_addr[1];
        dma_wdata = rq_wdata[1];
    endtask
    task automatic post(input int i, input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pend[i] = 1'b1;
        rq_rd[i] = r;
        rq_wr[i] = w;
        rq_addr[i] = a;
        rq_wdata[i] = d;
    endtask
    // One full access: model picks the winner, memory answers after lat strobe cycles, owner holds mfc for hold extra cycles.
    task automatic serve(input int lat, input int hold);
        int w;
        logic is_rd;
        w = (pend[1] && (starve == LIMIT || !pend[0])) ? 1 : 0;
        starve = (w == 0 && pend[1]) ? starve + 1 : 0;
        is_rd = rq_rd[w];
        drive();
        @(negedge clock);
        chk("grant_owner", owner, w);
        for (int c = 0; c < lat; c++) begin
            if (c > 0) @(negedge clock);
            chk("busy_read", mem_read, is_rd);
            chk("busy_write", mem_write, !is_rd);
            chk("busy_addr", mem_addr, rq_addr[w]);
            if (!is_rd) chk("busy_wdata", mem_wdata, rq_wdata[w]);
            chk("busy_mfc", {cpu_mfc, dma_mfc}, 2'b00);
            if (w == 0) begin
                cpu_addr = AW'($urandom);
                cpu_wdata = DW'($urandom);
            end else begin
                dma_addr = AW'($urandom);
                dma_wdata = DW'($urandom);
            end
        end
        mem_ready = 1'b1;
        mem_rdata = is_rd ? mem_val(rq_addr[w]) : DW'($urandom);
        if (is_rd) exp_rdata[w] = mem_rdata;
        else mem_arr[rq_addr[w]] = rq_wdata[w];
        @(negedge clock);
        mem_ready = 1'b0;
        chk("done_strobes", {mem_read, mem_write}, 2'b00);
        chk("done_mfc", mfc_of(w), 1'b1);
        chk("other_mfc", mfc_of(1 - w), 1'b0);
        chk("done_rdata", rdata_of(w), exp_rdata[w]);
        chk("other_rdata", rdata_of(1 - w), exp_rdata[1 - w]);
        chk("done_bus_err", bus_err, 1'b0);
        for (int h = 0; h < hold; h++) begin
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = DW'($urandom);
            @(negedge clock);
            chk("hold_mfc", mfc_of(w), 1'b1);
        end
        mem_ready = 1'b0;
        pend[w] = 1'b0;
        drive();
        @(negedge clock);
        chk("release_mfc", {cpu_mfc, dma_mfc}, 2'b00);
        chk("release_rdata", rdata_of(w), exp_rdata[w]);
    endtask
    initial begin : main
        logic [1:0] cmd;
        pend = '{1'b0, 1'b0};
        rq_rd = '{1'b0, 1'b0};
        rq_wr = '{1'b0, 1'b0};
        rq_addr = '{'0, '0};
        rq_wdata = '{'0, '0};
        exp_rdata = '{'0, '0};
        mem_ready = 1'b0;
        mem_rdata = '0;
        drive();
        repeat (2) @(negedge clock);
        chk("rst_flags", {mem_read, mem_write, cpu_mfc, dma_mfc, owner, bus_err}, 6'b0);
        chk("rst_mem_addr", mem_addr, 16'h0);
        chk("rst_mem_wdata", mem_wdata, 16'h0);
        chk("rst_cpu_rdata", cpu_rdata, 16'h0);
        chk("rst_dma_rdata", dma_rdata, 16'h0);
        reset = 1'b0;
        @(negedge clock);
        mem_arr[16'h0010] = 16'hBEEF;
        post(0, 1'b1, 1'b0, 16'h0010, 16'h0);
        serve(3, 1);
        chk("t1_cpu_rdata", cpu_rdata, 16'hBEEF);
        post(0, 1'b0, 1'b1, 16'h0020, 16'h1234);
        post(1, 1'b1, 1'b0, 16'h0030, 16'h0);
        serve(2, 0);
        serve(2, 1);
        chk("t2_dma_owner", owner, 1'b1);
        post(0, 1'b1, 1'b1, 16'h0020, 16'h7777);
        serve(2, 0);
        chk("t5_rw_rdata", cpu_rdata, 16'h1234);
        post(1, 1'b1, 1'b0, 16'h0300, 16'h0);
        for (int k = 0; k < LIMIT; k++) begin
            post(0, 1'b1, 1'b0, AW'(16'h0200 + k), 16'h0);
            serve(1 + k, 0);
            chk("starve_cpu_win", owner, 1'b0);
        end
        post(0, 1'b1, 1'b0, 16'h0210, 16'h0);
        serve(2, 1);
        chk("starve_dma_forced", owner, 1'b1);
        post(1, 1'b0, 1'b1, 16'h0301, 16'h5555);
        serve(2, 0);
        chk("starve_cleared", owner, 1'b0);
        serve(1, 0);
        for (int r = 0; r < 60; r++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && ($urandom_range(0, 9) < 6 || (i == 1 && !pend[0]))) begin
                    cmd = 2'($urandom_range(1, 3));
                    post(i, cmd[0], cmd[1], AW'($urandom_range(0, 15)), DW'($urandom));
                end
            end
            serve($urandom_range(1, 5), $urandom_range(0, 2));
        end
        while (pend[0] || pend[1]) serve(2, 0);
`ifdef ARB_TIMEOUT_EN
        post(0, 1'b1, 1'b0, 16'h0044, 16'h0);
        serve(TMO, 0);
        post(0, 1'b1, 1'b0, 16'h0045, 16'h0);
        starve = 0;
        drive();
        for (int c = 0; c < TMO; c++) begin
            @(negedge clock);
            chk("tmo_strobe_held", mem_read, 1'b1);
        end
        @(negedge clock);
        chk("tmo_strobe_drop", mem_read, 1'b0);
        chk("tmo_mfc", cpu_mfc, 1'b1);
        chk("tmo_bus_err", bus_err, 1'b1);
        chk("tmo_rdata", cpu_rdata, 16'h0);
        exp_rdata[0] = '0;
        pend[0] = 1'b0;
        drive();
        @(negedge clock);
        chk("tmo_release", {cpu_mfc, bus_err}, 2'b00);
`else
        post(0, 1'b1, 1'b0, 16'h0044, 16'h0);
        serve(TMO + 5, 0);
`endif
        post(1, 1'b0, 1'b1, 16'h0050, 16'hCAFE);
        drive();
        @(negedge clock);
        chk("rst_mid_grant", {owner, mem_write}, 2'b11);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_mid_strobes", {mem_read, mem_write}, 2'b00);
        chk("rst_mid_mfc", {cpu_mfc, dma_mfc}, 2'b00);
        chk("rst_mid_owner", owner, 1'b0);
        chk("rst_mid_rdata", cpu_rdata, 16'h0);
        reset = 1'b0;
        pend = '{1'b0, 1'b0};
        exp_rdata = '{'0, '0};
        starve = 0;
        drive();
        @(negedge clock);
        chk("rst_idle_mfc", dma_mfc, 1'b0);
        post(0, 1'b1, 1'b0, 16'h0050, 16'h0);
        serve(2, 0);
        chk("rst_after_read", cpu_rdata, 16'h0050 ^ 16'h5a3c);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single memory port (MAR/MDR side of the bus) between two requesters: the CPU controller and a DMA engine.
- Each requester raises a level read/write strobe with an address and write data, then waits for its MFC. The arbiter serialises the accesses and drives the memory handshake.
- CPU has fixed priority. A starvation counter forces a DMA grant after STARVE_LIMIT consecutive CPU wins.

Parameters:
AW, 16, address width
DW, 16, data width
STARVE_LIMIT, 4, consecutive CPU grants with DMA pending before DMA is forced to win (>=1)
TIMEOUT, 15, memory-ready timeout in cycles (used only with ARB_TIMEOUT_EN)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
cpu_read  in  1  CPU read request (level)
cpu_write  in  1  CPU write request (level)
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_mfc  out  1  memory-function-complete to CPU
cpu_rdata  out  DW  read data to CPU
dma_read  in  1  DMA read request
dma_write  in  1  DMA write request
dma_addr  in  AW  DMA address
dma_wdata  in  DW  DMA write data
dma_mfc  out  1  MFC to DMA
dma_rdata  out  DW  read data to DMA
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data
mem_ready  in  1  memory access complete
owner  out  1  current/last grant: 0 = CPU, 1 = DMA
bus_err  out  1  access terminated by timeout (always 0 without ARB_TIMEOUT_EN)

Behaviour:
Reset values (synchronous reset, active-high, clock `clock`):
- All outputs are 0 and the state is IDLE.
- Starvation counter is 0 and latched command is cleared.
- Reset asserted mid-access drops mem strobes and MFCs at that edge. No completion is reported.

States: IDLE, BUSY, HOLD.

IDLE:
- A requester is pending when its read or write is 1. If both read and write are 1, it is treated as a read.
- Winner selection:
  - DMA wins if starve_cnt == STARVE_LIMIT and DMA is pending.
  - Otherwise CPU wins if pending.
  - Otherwise DMA wins if pending.
- On a grant, the same edge:
  - latches owner, addr, wdata and cmd;
  - drives mem_addr, mem_wdata and mem_read or mem_write (registered);
  - goes to BUSY.
- Latency: request visible at edge N → mem strobe high after edge N.
- Starvation counter:
  - CPU grant with DMA pending: starve_cnt increments, saturating at STARVE_LIMIT.
  - DMA grant, or DMA not pending: starve_cnt clears to 0.

BUSY:
- Holds strobes, address and data stable.
- On the edge where mem_ready == 1:
  - captures mem_rdata into the owner's rdata register (reads only; writes leave it unchanged);
  - drops mem strobes;
  - sets the owner's mfc = 1;
  - goes to HOLD.

HOLD (four-phase handshake):
- Owner's mfc stays 1 while its read|write is 1.
- On the first edge with the owner's strobes both 0: mfc goes to 0 and the state returns to IDLE.
- A new grant is possible on the following edge, so the minimum gap between accesses is 1 idle cycle.
- The non-owner's strobes are ignored in BUSY and HOLD. The non-owner's mfc stays 0.

Other rules:
- rdata outputs hold their last value until the next read completion for that requester.
- Request inputs are sampled only in IDLE. Changes to addr/wdata after the grant have no effect.
- mem_ready while IDLE or HOLD is ignored.

Optional Feature:
ARB_TIMEOUT_EN:
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - If TIMEOUT cycles pass without mem_ready, the arbiter drops the strobes and goes to HOLD.
  - The owner's mfc is 1 and bus_err is 1. On a read, the owner's rdata is 0.
  - bus_err clears with mfc on leaving HOLD.
- Undefined: BUSY waits indefinitely for mem_ready and bus_err is tied to 0.

Test Plan:
1. CPU read: cpu_read=1, addr 0x0010. Memory returns 0xBEEF with mem_ready after 3 cycles → mem_read high 3 cycles at 0x0010; cpu_mfc=1, cpu_rdata=0xBEEF; cpu_read dropped → cpu_mfc=0 next edge, IDLE.
2. Simultaneous first request: cpu_write (0x0020, 0x1234) and dma_read (0x0030) on the same cycle → CPU write first (owner=0); DMA read granted after CPU handshake completes; dma_mfc never high during the CPU access.
3. Starvation with STARVE_LIMIT=4: DMA held pending while CPU issues back-to-back reads → exactly 4 CPU grants, then a DMA grant (owner=1) with the CPU still pending; starve_cnt=0 after.
4. Reset mid-access: reset asserted during BUSY of a DMA write → next edge mem_write=0, dma_mfc=0, owner=0; a CPU read after reset is served normally.
5. Read+write both asserted by the CPU → mem_read=1, mem_write=0 for the access.
6. With ARB_TIMEOUT_EN, TIMEOUT=15: CPU read and mem_ready never asserted → strobe drops after 15 BUSY cycles; cpu_mfc=1, bus_err=1, cpu_rdata=0; both clear after cpu_read falls.
